// File: rtl/snake_pkg.sv
// Shared encodings for the snake heading and the relative turn requests.
package snake_pkg;

  typedef logic [1:0] heading_t;

  localparam heading_t HEAD_UP    = 2'd0;
  localparam heading_t HEAD_RIGHT = 2'd1;
  localparam heading_t HEAD_DOWN  = 2'd2;
  localparam heading_t HEAD_LEFT  = 2'd3;

  localparam logic TURN_LEFT  = 1'b0;
  localparam logic TURN_RIGHT = 1'b1;

  // Clockwise is +1; the 2-bit result wraps naturally (LEFT+1=UP, UP-1=LEFT).
  function automatic heading_t apply_turn(heading_t head, logic turn);
    heading_t next_head;
    if (turn == TURN_RIGHT) begin
      next_head = head + 2'd1;
    end else begin
      next_head = head - 2'd1;
    end
    return next_head;
  endfunction

endpackage

// File: rtl/turn_fifo.sv
// 1-bit-wide FIFO of pending relative turns; flush wins over push/pop, full/empty are registered.
module turn_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A pop in the same cycle frees the slot a full-queue push needs.
  assign do_pop  = pop && !empty_q && !flush;
  assign do_push = push && (!full_q || do_pop) && !flush;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/snake_turn_queue.sv
// Buffers rotary-encoder turn pulses and applies at most one queued relative turn per game tick to the heading.
module snake_turn_queue
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [1:0]  INIT_HEADING = 2'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rot_l_oneshot,
  input  logic                   rot_r_oneshot,
  input  logic                   game_tick,
  input  logic                   game_run,
  input  logic                   restart,
  output logic [1:0]             heading,
  output logic                   turn_applied,
  output logic                   turn_dropped,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   queue_full
);

  heading_t heading_q, heading_d;
  logic     applied_q, applied_d;
  logic     dropped_q, dropped_d;

  logic active;
  logic req_one, req_both;
  logic do_pop, do_push;
  logic head_turn;
  logic fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign active   = game_run && !restart;
  assign req_one  = rot_l_oneshot ^ rot_r_oneshot;
  assign req_both = rot_l_oneshot & rot_r_oneshot;

  // Pop is decided before push, so a same-cycle request never overtakes the queue head.
  assign do_pop  = active && game_tick && !fifo_empty;
  assign do_push = active && req_one && (!fifo_full || do_pop);

  turn_fifo #(
    .DEPTH (DEPTH)
  ) u_turn_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .push_data (rot_r_oneshot ? TURN_RIGHT : TURN_LEFT),
    .pop       (do_pop),
    .flush     (restart),
    .pop_data  (head_turn),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    heading_d = heading_q;
    applied_d = 1'b0;
    dropped_d = 1'b0;
    if (restart) begin
      heading_d = INIT_HEADING;
    end else if (active) begin
      if (do_pop) begin
        heading_d = apply_turn(heading_q, head_turn);
        applied_d = 1'b1;
      end
      dropped_d = req_both || (req_one && fifo_full && !do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heading_q <= INIT_HEADING;
      applied_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      heading_q <= heading_d;
      applied_q <= applied_d;
      dropped_q <= dropped_d;
    end
  end

  assign heading      = heading_q;
  assign turn_applied = applied_q;
  assign turn_dropped = dropped_q;
  assign pending      = fifo_count;
  assign queue_full   = fifo_full;

endmodule

// File: tb/tb_snake_turn_queue.sv
// Directed bench for snake_turn_queue: behavioural queue model plus a heading scoreboard per applied turn.
module tb_snake_turn_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [1:0]  INIT  = 2'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rot_l_oneshot, rot_r_oneshot, game_tick, game_run, restart;
  logic [1:0] heading;
  logic       turn_applied, turn_dropped, queue_full;
  logic [2:0] pending;

  int errors = 0;
  int checks = 0;

  bit         model_q[$];
  logic [1:0] sb[$];
  logic [1:0] mh;
  logic       exp_applied, exp_dropped;

  always #5 clk = ~clk;

  snake_turn_queue #(
    .DEPTH        (DEPTH),
    .INIT_HEADING (INIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rot_l_oneshot (rot_l_oneshot),
    .rot_r_oneshot (rot_r_oneshot),
    .game_tick     (game_tick),
    .game_run      (game_run),
    .restart       (restart),
    .heading       (heading),
    .turn_applied  (turn_applied),
    .turn_dropped  (turn_dropped),
    .pending       (pending),
    .queue_full    (queue_full)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("turn_applied", 8'(turn_applied), 8'(exp_applied));
    check("turn_dropped", 8'(turn_dropped), 8'(exp_dropped));
    if (turn_applied === 1'b1) begin
      check("apply_expected", 8'(sb.size() > 0), 8'd1);
      if (sb.size() > 0) check("applied_heading", 8'(heading), 8'(sb.pop_front()));
    end
    check("heading", 8'(heading), 8'(mh));
    check("pending", 8'(pending), 8'(model_q.size()));
    check("queue_full", 8'(queue_full), 8'(model_q.size() == DEPTH));
  endtask

  // Drive one cycle of inputs, advance the model, then compare #1 after the edge.
  task automatic step(input logic l, input logic r, input logic tick, input logic run,
                      input logic rs);
    bit full_now, pop_now, t;
    rot_l_oneshot = l;
    rot_r_oneshot = r;
    game_tick     = tick;
    game_run      = run;
    restart       = rs;
    exp_applied   = 1'b0;
    exp_dropped   = 1'b0;
    if (rs) begin
      mh = INIT;
      model_q.delete();
    end else if (run) begin
      full_now = (model_q.size() == DEPTH);
      pop_now  = tick && (model_q.size() > 0);
      exp_dropped = (l && r) || ((l ^ r) && full_now && !pop_now);
      if (pop_now) begin
        t  = model_q.pop_front();
        mh = t ? mh + 2'd1 : mh - 2'd1;
        sb.push_back(mh);
        exp_applied = 1'b1;
      end
      if ((l ^ r) && (!full_now || pop_now)) model_q.push_back(r);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    rot_l_oneshot = 1'b0;
    rot_r_oneshot = 1'b0;
    game_tick = 1'b0;
    game_run = 1'b1;
    restart = 1'b0;
    mh = INIT;
    exp_applied = 1'b0;
    exp_dropped = 1'b0;
    #12;
    check_state();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three right turns spaced out, then three ticks: heading 1->2->3->0.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(4);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(1);
    end

    // From UP, left wraps to LEFT, then DOWN.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Restart discards its own request; then overfill with six lefts.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Conflicting pulses drop; tick on an empty queue is a no-op.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Request with a tick on an empty queue lands on the following tick.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Full queue: push alongside pop is accepted with no drop.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Pause holds everything and does not report drops.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Async reset mid-queue, observed between clock edges.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rot_l_oneshot = 1'b0;
    rot_r_oneshot = 1'b0;
    game_tick = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    mh = INIT;
    model_q.delete();
    exp_applied = 1'b0;
    exp_dropped = 1'b0;
    check_state();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state();

    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
